// File: rtl/band_serializer_if.sv
// Serialized band-sample stream from band_serializer to its sink.
// Handshake: a word moves when out_valid and out_ready are both 1 on a rising edge.
// While out_valid=1 and out_ready=0, out_data and out_chan stay stable.
// out_ready has no effect while out_valid=0.
interface band_serializer_if #(
  parameter int DW = 10
) ();
  logic [DW-1:0] out_data;
  logic [1:0]    out_chan;
  logic          out_valid;
  logic          out_ready;

  modport master (output out_data, output out_chan, output out_valid, input out_ready);
  modport slave  (input out_data, input out_chan, input out_valid, output out_ready);
endinterface

// File: rtl/band_serializer.sv
// Captures whole filter-bank frames into a frame FIFO and serializes them,
// one band per handshake, onto a valid/ready stream.
module band_serializer #(
  parameter int DW     = 10,
  parameter int NCH    = 4,
  parameter int FDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clk_enable,
  input  logic                      frame_strobe,
  input  logic [NCH*DW-1:0]         band_in,
  band_serializer_if.master         out_if,
  output logic                      overflow,
  output logic [$clog2(FDEPTH):0]   fifo_level,
  output logic                      o_dbg_state
);
  localparam int AW = $clog2(FDEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [NCH*DW-1:0] r_mem [FDEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic [NCH*DW-1:0] r_frame;
  logic [1:0]        r_chan, w_chan_nxt;
  logic              r_ovf;
  logic              w_hs, w_pop, w_empty, w_full, w_last, w_wr_req, w_wr_acc;

  assign w_empty  = (r_level == '0);
  assign w_full   = (r_level == LW'(FDEPTH));
  assign w_hs     = (r_state == SEND) && out_if.out_ready;
  assign w_last   = (r_chan == 2'(NCH - 1));
  assign w_wr_req = frame_strobe & clk_enable;
  // A full FIFO still takes the frame when the head leaves on the same edge.
  assign w_wr_acc = w_wr_req & (~w_full | w_pop);

  always_comb begin
    w_state_nxt = r_state;
    w_chan_nxt  = r_chan;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_chan_nxt  = '0;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (w_hs) begin
          if (!w_last) begin
            w_chan_nxt = r_chan + 2'd1;
          end else if (!w_empty) begin
            w_pop      = 1'b1;
            w_chan_nxt = '0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_frame  <= '0;
      r_chan   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_chan <= w_chan_nxt;
      if (w_pop) begin
        r_frame  <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_level <= r_level + LW'(w_wr_acc) - LW'(w_pop);
      if (w_wr_req && !w_wr_acc) r_ovf <= 1'b1;
    end
  end

  // Storage needs no reset: only entries counted by r_level are ever read.
  always_ff @(posedge clk) begin
    if (!reset && w_wr_acc) r_mem[r_wr_ptr] <= band_in;
  end

  assign out_if.out_valid = (r_state == SEND);
  assign out_if.out_data  = r_frame[r_chan*DW +: DW];
  assign out_if.out_chan  = r_chan;
  assign overflow         = r_ovf;
  assign fifo_level       = r_level;
  assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_band_serializer.sv
// Bench for band_serializer: queue-based frame model plus word scoreboard,
// directed scenarios followed by randomized traffic.
module tb_band_serializer;
  localparam int DW     = 10;
  localparam int NCH    = 4;
  localparam int FDEPTH = 4;
  localparam int BW     = NCH * DW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clk_enable = 1'b0;
  logic          frame_strobe = 1'b0;
  logic [BW-1:0] band_in = '0;
  logic          ready = 1'b0;
  logic          overflow;
  logic [2:0]    fifo_level;
  logic          dbg_state;

  band_serializer_if #(.DW(DW)) bus ();
  assign bus.out_ready = ready;

  band_serializer #(.DW(DW), .NCH(NCH), .FDEPTH(FDEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_enable   (clk_enable),
    .frame_strobe (frame_strobe),
    .band_in      (band_in),
    .out_if       (bus.master),
    .overflow     (overflow),
    .fifo_level   (fifo_level),
    .o_dbg_state  (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard and reference model state
  int            n_vec = 0;
  int            n_err = 0;
  logic [DW+1:0] exp_q[$];
  logic [BW-1:0] m_q[$];
  logic [BW-1:0] m_cur = '0;
  int            m_idx = 0;
  bit            m_busy = 1'b0;
  bit            m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: advance the model from the inputs now applied, then check the DUT after the edge.
  task automatic step();
    bit hs, pop, wr, acc;
    if (reset) begin
      m_q.delete();
      exp_q.delete();
      m_busy = 1'b0;
      m_idx  = 0;
      m_ovf  = 1'b0;
      m_cur  = '0;
    end else begin
      if (bus.out_valid && ready) begin
        if (exp_q.size() == 0) chk("sb_unexpected_word", 1, 0);
        else chk("sb_word", {bus.out_chan, bus.out_data}, exp_q.pop_front());
      end
      hs  = m_busy && ready;
      pop = (m_q.size() > 0) && (!m_busy || (hs && m_idx == NCH - 1));
      wr  = frame_strobe && clk_enable;
      acc = wr && ((m_q.size() < FDEPTH) || pop);
      if (pop) begin
        m_cur  = m_q.pop_front();
        m_idx  = 0;
        m_busy = 1'b1;
      end else if (hs) begin
        if (m_idx < NCH - 1) m_idx++;
        else m_busy = 1'b0;
      end
      if (acc) begin
        m_q.push_back(band_in);
        for (int k = 0; k < NCH; k++) exp_q.push_back({2'(k), band_in[k*DW +: DW]});
      end else if (wr) begin
        m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("valid", bus.out_valid, m_busy);
    chk("level", fifo_level, m_q.size());
    chk("overflow", overflow, m_ovf);
    if (m_busy) begin
      chk("data", bus.out_data, m_cur[m_idx*DW +: DW]);
      chk("chan", bus.out_chan, m_idx);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic strobe(input logic [BW-1:0] b, input logic en);
    band_in      = b;
    clk_enable   = en;
    frame_strobe = 1'b1;
    step();
    frame_strobe = 1'b0;
    clk_enable   = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    steps(2);
    reset = 1'b0;
  endtask

  function automatic logic [BW-1:0] rnd_band();
    return BW'({$urandom(), $urandom()});
  endfunction

  initial begin
    // reset state
    do_reset();
    chk("rst_data", bus.out_data, 0);
    chk("rst_chan", bus.out_chan, 0);

    // single frame, bands 3..0 = -1, +1, -512, +511
    ready = 1'b1;
    strobe({10'h3FF, 10'h001, 10'h200, 10'h1FF}, 1'b1);
    chk("lat_not_yet", bus.out_valid, 0);
    step();
    chk("lat_valid", bus.out_valid, 1);
    chk("lat_chan0_data", bus.out_data, 10'h1FF);
    steps(6);

    // backpressure for 10 cycles at chan 1
    ready = 1'b0;
    strobe(rnd_band(), 1'b1);
    steps(1);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("bp_chan", bus.out_chan, 1);
    steps(10);
    ready = 1'b1;
    steps(6);

    // overflow: six strobes, six cycles apart, sink stalled
    ready = 1'b0;
    for (int f = 0; f < 6; f++) begin
      strobe(rnd_band(), 1'b1);
      steps(5);
    end
    chk("ovf_level", fifo_level, 4);
    chk("ovf_flag", overflow, 1);
    ready = 1'b1;
    steps(30);
    chk("ovf_drained", exp_q.size(), 0);

    // full FIFO plus pop on the chan 3 handshake
    do_reset();
    ready = 1'b0;
    for (int f = 0; f < 5; f++) begin
      strobe(rnd_band(), 1'b1);
      steps(5);
    end
    ready = 1'b1;
    steps(3);
    strobe(rnd_band(), 1'b1);
    chk("fullpop_level", fifo_level, 4);
    chk("fullpop_ovf", overflow, 0);
    steps(30);

    // reset in mid-frame at chan 2
    strobe(rnd_band(), 1'b1);
    for (int i = 0; i < 20 && !(m_busy && m_idx == 2); i++) step();
    chk("midrst_reached", m_busy && m_idx == 2, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_valid", bus.out_valid, 0);
    strobe(rnd_band(), 1'b1);
    steps(8);

    // clk_enable low while a frame drains
    strobe(rnd_band(), 1'b1);
    steps(2);
    strobe(rnd_band(), 1'b0);
    chk("en0_level", fifo_level, 0);
    steps(6);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      frame_strobe = (c % 6 == 0);
      clk_enable   = ($urandom_range(0, 9) != 0);
      ready        = ($urandom_range(0, 2) != 0);
      band_in      = rnd_band();
      reset        = ($urandom_range(0, 499) == 0);
      step();
    end
    reset        = 1'b0;
    frame_strobe = 1'b0;
    ready        = 1'b1;
    steps(40);
    chk("final_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/band_serializer.md
BAND_SERIALIZER -- requirements
Module: band_serializer

Interface
REQ-001 Parameter DW, default 10, sample width in bits; all samples are signed two's complement, sfix DW-2 fractional bits.
REQ-002 Parameter NCH, default 4, number of filter-bank outputs per frame.
REQ-003 Parameter FDEPTH, default 4, frame FIFO depth in frames; power of two, at least 2.
REQ-004 Port clk, input, 1 bit: clock; all logic is rising-edge.
REQ-005 Port reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 Port clk_enable, input, 1 bit: qualifies frame capture only.
REQ-007 Port frame_strobe, input, 1 bit: one-cycle pulse when a complete band frame is present on band_in, once per 6-phase filter cycle.
REQ-008 Port band_in, input, NCH*DW bits: band k occupies bits [k*DW +: DW].
REQ-009 Port out_data, output, DW bits: current serialized sample.
REQ-010 Port out_chan, output, 2 bits: band index of out_data.
REQ-011 Port out_valid, output, 1 bit: out_data and out_chan are valid.
REQ-012 Port out_ready, input, 1 bit: the sink accepts the word.
REQ-013 Port overflow, output, 1 bit: sticky frame-drop flag.
REQ-014 Port fifo_level, output, clog2(FDEPTH)+1 bits: number of frames held in the FIFO, excluding the frame being sent.

Function
REQ-015 Capture: when frame_strobe and clk_enable are both 1, all NCH bands are written into the FIFO as one entry at that clock edge, with no modification of the values.
REQ-016 Write acceptance: a write is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle; in the full-with-pop case the level is unchanged.
REQ-017 Drop: a capture request on a full FIFO with no same-cycle pop is discarded, FIFO contents are unchanged, and overflow is set to 1 at that edge.
REQ-018 overflow, once set, stays 1 until reset.
REQ-019 The FSM has two states, IDLE and SEND, plus a frame register and a channel counter chan.
REQ-020 IDLE: if the FIFO is non-empty, pop the head into the frame register, set chan=0, and go to SEND; otherwise stay in IDLE.
REQ-021 SEND: out_valid=1, out_data=frame[chan], out_chan=chan.
REQ-022 A handshake is out_valid and out_ready both 1 in the same cycle; without a handshake, out_data, out_chan and out_valid hold stable.
REQ-023 Handshake with chan<NCH-1: chan increments by 1 and the state stays SEND.
REQ-024 Handshake with chan=NCH-1 and FIFO non-empty: pop the next frame, set chan=0, and stay in SEND, giving back-to-back frames with no bubble.
REQ-025 Handshake with chan=NCH-1 and FIFO empty: go to IDLE; out_valid=0 in the next cycle.
REQ-026 In IDLE, out_valid=0, and out_data and out_chan hold their last values.
REQ-027 Latency: with the FIFO empty and the FSM in IDLE, a capture at edge N gives out_valid=1 with chan 0 in the cycle after edge N+1, i.e. 2 cycles after the strobe cycle.
REQ-028 Simultaneous capture and pop on a non-full FIFO: both take effect and fifo_level is unchanged.
REQ-029 A capture into an empty FIFO while in IDLE is popped on the following edge and never delays the write.
REQ-030 FIFO pointers wrap modulo FDEPTH; fifo_level ranges from 0 to FDEPTH.
REQ-031 Throughput: a sink holding out_ready=1 continuously drains NCH words per frame, which exceeds the strobe rate of 1 per 6 cycles, so no overflow occurs.
REQ-032 out_ready is ignored while out_valid=0.
REQ-033 clk_enable=0 does not stall the FSM or the output handshake.

Reset
REQ-034 While reset=1 at a clock edge, the following are cleared: state=IDLE, FIFO pointers=0, fifo_level=0, chan=0, frame register=0, out_data=0, out_chan=0, out_valid=0, overflow=0.
REQ-035 Reset overrides every same-cycle event: a strobe during reset is not captured and an in-flight frame is discarded.
REQ-036 The first capture is accepted on the first edge after reset deasserts.

Verification
REQ-037 Single frame: reset; strobe with band_in={-1,+1,-512,+511} (bands 3..0), out_ready=1 -> out_valid rises 2 cycles later and outputs (chan, data) = (0,511), (1,-512), (2,1), (3,-1) on consecutive cycles, then out_valid=0.
REQ-038 Backpressure: out_ready=0 for 10 cycles mid-frame at chan=1 -> out_data and out_chan stay stable and the remaining words are delivered in order once ready returns.
REQ-039 Overflow: out_ready=0 and 6 strobes every 6 cycles -> the first frame goes to the frame register, the next 4 fill the FIFO (fifo_level=4), the 6th is dropped with overflow=1; draining then yields exactly 5 frames in order.
REQ-040 Full plus pop: FIFO full, strobe in the same cycle as the chan=3 handshake -> frame accepted, overflow stays 0, fifo_level stays 4.
REQ-041 Reset mid-frame: assert reset at chan=2 -> next cycle out_valid=0, fifo_level=0, overflow=0; a following strobe is delivered starting from chan 0.
REQ-042 clk_enable=0: strobe with clk_enable=0 -> no capture and fifo_level unchanged, while an in-progress frame continues to drain.
